uart_rx_cfg: RTL

- Parametrised UART receiver: the next generation of the team's fixed 8N1 receiver.
- Adds configurable data width, parity, stop bits and oversampling, plus 3-sample majority voting and error reporting.
- Delivers frames over a valid/ready interface with a one-entry holding register and overrun detection.
- Sits between the board RX pin and the command/packet parser.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_cfg.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, parity constants and divider helper for the configurable UART
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, one-cycle tick every DIV clocks
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Suppressed on the restart cycle so the first tick lands a full DIV later
  assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised UART receiver with majority voting and valid/ready output
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_break,
  output logic                 rx_busy
);

  localparam int            DIV       = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int            TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_S0      = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1      = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_RES     = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_END     = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
        DIV < 1) begin : g_bad_param
      $fatal(1, "uart_rx_cfg: illegal parameter set");
    end
  endgenerate

  logic [1:0]           sync_q;
  logic                 rx_prev, rx_s, fall;
  uart_state_e          state, state_nxt;
  logic                 tick, restart, tick_res, tick_end, maj;
  logic [TW-1:0]        tick_idx;
  logic [3:0]           bit_cnt;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q, ferr_q, brk_wait;
  logic                 frame_done, break_det, is_break, ferr_new, perr_new;

  assign rx_s     = sync_q[1];
  assign fall     = rx_prev & ~rx_s;
  assign rx_busy  = (state != ST_IDLE);
  assign tick_res = tick && (tick_idx == T_RES);
  assign tick_end = tick && (tick_idx == T_END);
  // Third vote is the live synchronised sample at the resolve tick
  assign maj      = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
  assign is_break = (shift_q == '0) && (PARITY == PAR_NONE || !par_q) && !maj;
  assign ferr_new = ferr_q | ~maj;

  always_comb begin
    perr_new = 1'b0;
    if (PARITY == PAR_ODD) begin
      perr_new = ~(^shift_q ^ par_q);
    end else if (PARITY == PAR_EVEN) begin
      perr_new = ^shift_q ^ par_q;
    end
  end

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    restart    = 1'b0;
    frame_done = 1'b0;
    break_det  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall) begin
          state_nxt = ST_START;
          restart   = 1'b1;
        end
      end
      ST_START: begin
        if (tick_res && maj) begin
          state_nxt = ST_IDLE;
        end else if (tick_end) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick_end && bit_cnt == LAST_DATA) begin
          state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (tick_end) begin
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (brk_wait) begin
          if (rx_s) begin
            state_nxt = ST_IDLE;
          end
        end else if (tick_res) begin
          if (bit_cnt == 4'd0 && is_break) begin
            break_det = 1'b1;
          end else if (bit_cnt == LAST_STOP) begin
            frame_done = 1'b1;
            state_nxt  = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q        <= 2'b11;
      rx_prev       <= 1'b1;
      tick_idx      <= '0;
      bit_cnt       <= 4'd0;
      samp          <= 2'b00;
      shift_q       <= '0;
      par_q         <= 1'b0;
      ferr_q        <= 1'b0;
      brk_wait      <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_break      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx};
      rx_prev    <= sync_q[1];
      rx_overrun <= 1'b0;
      rx_break   <= break_det;

      if (restart) begin
        tick_idx <= '0;
      end else if (tick) begin
        tick_idx <= (tick_idx == T_END) ? '0 : tick_idx + TW'(1);
      end
      if (tick && tick_idx == T_S0) samp[0] <= rx_s;
      if (tick && tick_idx == T_S1) samp[1] <= rx_s;

      case (state)
        ST_IDLE: begin
          bit_cnt  <= 4'd0;
          ferr_q   <= 1'b0;
          brk_wait <= 1'b0;
        end
        ST_DATA: begin
          if (tick_res) shift_q <= {maj, shift_q[DATA_BITS-1:1]};
          if (tick_end) bit_cnt <= (bit_cnt == LAST_DATA) ? 4'd0 : bit_cnt + 4'd1;
        end
        ST_PARITY: begin
          if (tick_res) par_q <= maj;
        end
        ST_STOP: begin
          if (break_det) brk_wait <= 1'b1;
          if (!brk_wait && tick_res) ferr_q <= ferr_new;
          if (!brk_wait && tick_end) bit_cnt <= bit_cnt + 4'd1;
        end
        default: ;
      endcase

      // Load and accept may coincide; otherwise a full register drops the new frame
      if (frame_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data       <= shift_q;
          rx_valid      <= 1'b1;
          rx_parity_err <= perr_new;
          rx_frame_err  <= ferr_new;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
